// File: rtl/buff_uart_host_pkg.sv
// Shared bus package for the buffered UART host and the peripherals it addresses.
// Provides the bus transaction state encoding, the transfer direction type and
// the gap counter width.
package buff_uart_host_pkg;

    // Width of the inter-transaction gap counter (gap_cycles range 0..15).
    localparam int unsigned GapCntW = 4;

    // Bus transaction sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StStrobe,
        StCapture,
        StGap
    } state_e;

    // Direction of a bus transfer.
    typedef enum logic {
        DirRead  = 1'b0,
        DirWrite = 1'b1
    } dir_e;

endpackage

// File: rtl/buff_uart_host_if.sv
// Signal bundle between a command client, the buffered UART host and the
// peripheral bus.
//   cmd_*  : command channel (client -> host), valid/ready handshake
//   rsp_*  : read response channel (host -> client), valid/ready handshake
//   bus_*, active_address, write_enable, read_enable : peripheral bus
// Modports:
//   slave  : the host's view (accepts commands, drives the bus)
//   master : the client / environment view
interface buff_uart_host_if #(
    parameter int unsigned width         = 8,
    parameter int unsigned address_width = 4
) ();

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [width-1:0]         cmd_data;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [width-1:0]         rsp_data;

    logic [address_width-1:0] active_address;
    logic                     write_enable;
    logic                     read_enable;
    logic [width-1:0]         bus_data_out;
    logic                     bus_data_oe;
    logic [width-1:0]         bus_data_in;

    modport slave (
        input  cmd_valid, cmd_write, cmd_data, rsp_ready, bus_data_in,
        output cmd_ready, rsp_valid, rsp_data, active_address, write_enable,
               read_enable, bus_data_out, bus_data_oe
    );

    modport master (
        output cmd_valid, cmd_write, cmd_data, rsp_ready, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_data, active_address, write_enable,
               read_enable, bus_data_out, bus_data_oe
    );

endinterface

// File: rtl/buff_uart_host_gap_timer.sv
// Down-counter timing the idle gap between bus transactions.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load load_val_i into the counter
//   load_val_i   : gap length in cycles
//   dec_i        : count down by one (saturates at zero)
//   done_o       : high in the final gap cycle, so the count reaches zero as
//                  the sequencer leaves the gap
module buff_uart_host_gap_timer
    import buff_uart_host_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [GapCntW-1:0] load_val_i,
    input  logic               dec_i,
    output logic               done_o
);

    logic [GapCntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - GapCntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q <= GapCntW'(1));

endmodule

// File: rtl/buff_uart_host.sv
// Buffered UART host: turns single write/read commands into timed transactions
// on a simple addressed peripheral bus. Writes go to tx_address, reads come
// from rx_address and are returned on a one-deep response buffer.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   host_if      : command/response channels and peripheral bus (slave view)
// Sequence: IDLE -> ADDR -> STROBE -> [CAPTURE for reads] -> GAP -> IDLE.
module buff_uart_host
    import buff_uart_host_pkg::*;
#(
    parameter int unsigned width         = 8,
    parameter int unsigned address_width = 4,
    parameter int unsigned tx_address    = 1,
    parameter int unsigned rx_address    = 2,
    parameter int unsigned gap_cycles    = 1
) (
    input  logic           clock,
    input  logic           reset,
    buff_uart_host_if.slave host_if
);

    localparam logic [address_width-1:0] TxAddr    = address_width'(tx_address);
    localparam logic [address_width-1:0] RxAddr    = address_width'(rx_address);
    localparam logic [GapCntW-1:0]       GapCycles = GapCntW'(gap_cycles);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [width-1:0] data_q, data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [width-1:0] rsp_data_q, rsp_data_d;

    logic cmd_ready;
    logic timer_load;
    logic timer_dec;
    logic timer_done;

    // A read is refused while a response is still pending, so the single
    // response buffer can never be overwritten. Writes are always accepted.
    assign cmd_ready = (state_q == StIdle) && !(rsp_valid_q && !host_if.cmd_write);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        data_d     = data_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host_if.cmd_valid && cmd_ready) begin
                    dir_d   = host_if.cmd_write ? DirWrite : DirRead;
                    data_d  = host_if.cmd_write ? host_if.cmd_data : '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                if (dir_q == DirRead) begin
                    state_d = StCapture;
                end else if (GapCycles == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_load = 1'b1;
                    state_d    = StGap;
                end
            end
            StCapture: begin
                if (GapCycles == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_load = 1'b1;
                    state_d    = StGap;
                end
            end
            StGap: begin
                timer_dec = 1'b1;
                if (timer_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response buffer. A load from CAPTURE wins over a same-cycle handshake so
    // the fresh value is never dropped.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_valid_q && host_if.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (state_q == StCapture) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = host_if.bus_data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            dir_q       <= DirRead;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    buff_uart_host_gap_timer u_gap_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (timer_load),
        .load_val_i (GapCycles),
        .dec_i      (timer_dec),
        .done_o     (timer_done)
    );

    // Bus outputs are decoded from state so reset clears them in the same edge.
    assign host_if.cmd_ready      = cmd_ready;
    assign host_if.rsp_valid      = rsp_valid_q;
    assign host_if.rsp_data       = rsp_data_q;
    assign host_if.active_address = (state_q == StIdle) ? '0 :
                                    (dir_q == DirWrite) ? TxAddr : RxAddr;
    assign host_if.write_enable   = (state_q == StStrobe) && (dir_q == DirWrite);
    assign host_if.read_enable    = (state_q == StStrobe) && (dir_q == DirRead);
    assign host_if.bus_data_oe    = (dir_q == DirWrite) &&
                                    ((state_q == StAddr) || (state_q == StStrobe));
    assign host_if.bus_data_out   = host_if.bus_data_oe ? data_q : '0;

endmodule
